// File: rtl/core_pkg.sv
// core_pkg: shared opcodes, FSM encoding, writeback and size codes for the RV32I core
package core_pkg;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_MISCMEM = 7'b0001111;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd7
  } state_t;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  function automatic logic legal_op(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                      OP_OP, OP_OPIMM, OP_AUIPC, OP_LUI, OP_MISCMEM};
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == HALF && a[0]) || (sz == WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: RV32I immediate extraction (I/S/B/U/J) from the instruction word
module imm_gen (
  input  logic [31:7] ir,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle RV32I sequencer owning pc/ir; CORE_SEQ_PERF_CNT_EN adds cycle/instret counters
module core_seq
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       inst,
  input  logic [31:0]       alu_out,
  input  logic              cmp_out,
  output logic [31:0]       pc,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] i_addr,
  output logic [ADDR_W-1:0] d_addr,
  output logic              ram_w_en,
  output logic              reg_w_en,
  output logic [1:0]        wb_sel,
  output logic [2:0]        state,
  output logic              retire,
  output logic              trap
`ifdef CORE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);
  state_t st, st_n;
  logic [ADDR_W-1:0] result;
  logic [31:0] tgt, pc_n, pc4, br_t, jmp_t;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0] op;
  logic is_jmp, is_ls, unused_imm;
  imm_gen u_imm (
    .ir(ir[31:7]),
    .imm_i(imm_i),
    .imm_s(imm_s),
    .imm_b(imm_b),
    .imm_u(imm_u),
    .imm_j(imm_j)
  );
  assign unused_imm = ^{imm_i, imm_s, imm_u};
  assign op = ir[6:0];
  assign is_jmp = op == OP_JAL || op == OP_JALR;
  assign is_ls = op == OP_LOAD || op == OP_STORE;
  assign pc4 = pc + 32'd4;
  assign br_t = cmp_out ? pc + imm_b : pc4;
  assign jmp_t = op == OP_JAL ? pc + imm_j : alu_out & ~32'd1;
  always_comb begin
    st_n = st;
    pc_n = pc;
    case (st)
      FETCH:  st_n = DECODE;
      DECODE: st_n = READ;
      READ:   st_n = legal_op(op) ? EXEC : TRAP;
      EXEC: begin
        st_n = (op == OP_BRANCH && br_t[1:0] != 2'b00) || (is_jmp && jmp_t[1:0] != 2'b00) ||
               (is_ls && misaligned(ir[13:12], alu_out[1:0])) ? TRAP :
               op == OP_BRANCH || op == OP_MISCMEM ? FETCH : is_ls ? MEM : WB;
        pc_n = st_n != FETCH ? pc : op == OP_BRANCH ? br_t : pc4;
      end
      MEM: begin
        st_n = op == OP_STORE ? FETCH : WB;
        pc_n = op == OP_STORE ? pc4 : pc;
      end
      WB: begin
        st_n = FETCH;
        pc_n = is_jmp ? tgt : pc4;
      end
      default: st_n = TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      result <= '0;
      tgt <= '0;
    end else begin
      st <= st_n;
      pc <= pc_n;
      if (st == DECODE) ir <= inst;
      if (st == EXEC) begin
        result <= alu_out[ADDR_W-1:0];
        tgt <= jmp_t;
      end
    end
  end
  // every completing path (branch/fence, store, writeback) is exactly a transition back to FETCH
  assign retire = !reset && st_n == FETCH;
  assign ram_w_en = !reset && st == MEM && op == OP_STORE;
  assign reg_w_en = !reset && st == WB && ir[11:7] != 5'd0;
  assign wb_sel = op == OP_LOAD ? WB_MEM : is_jmp ? WB_PC4 : WB_ALU;
  assign state = st;
  assign trap = st == TRAP;
  assign i_addr = pc[ADDR_W-1:0];
  assign d_addr = result;
`ifdef CORE_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      instret_cnt <= instret_cnt + {31'd0, retire};
    end
  end
`endif
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: directed and randomized checks of core_seq against a per-instruction outcome model
module tb_core_seq;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, OPR = 7'b0110011, OPI = 7'b0010011, AUI = 7'b0010111,
                         LU = 7'b0110111, MSC = 7'b0001111;
  typedef struct {
    int lat;
    bit trp;
    logic [31:0] npc;
    int regw;
    logic [1:0] wb;
    int ramw;
    logic [13:0] da;
  } exp_t;
  logic clk = 0, reset = 1, cmp_out = 0;
  logic [31:0] inst = 0, alu_out = 0, pc, ir;
  logic [13:0] i_addr, d_addr;
  logic ram_w_en, reg_w_en, retire, trap;
  logic [1:0] wb_sel;
  logic [2:0] state;
`ifdef CORE_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  int checks = 0, errors = 0;
  int o_lat, o_regw, o_ramw;
  logic o_trap, o_trap_end, o_fetch_ok, o_excl_ok;
  logic [31:0] o_pc, o_ir, mpc;
  logic [1:0] o_wb;
  logic [13:0] o_da;
  always #5 clk = ~clk;
  core_seq #(.RESET_PC(RESET_PC), .ADDR_W(14)) dut (
    .clk(clk), .reset(reset), .inst(inst), .alu_out(alu_out), .cmp_out(cmp_out),
    .pc(pc), .ir(ir), .i_addr(i_addr), .d_addr(d_addr), .ram_w_en(ram_w_en),
    .reg_w_en(reg_w_en), .wb_sel(wb_sel), .state(state), .retire(retire), .trap(trap)
`ifdef CORE_SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'($urandom), f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'($urandom), 5'($urandom), f3, imm[4:0], ST};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'($urandom), 5'($urandom), f3, imm[4:1], imm[11], BR};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JL};
  endfunction

  // outcome of one instruction started at p: completion cycle, next pc and side effects
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                                 input logic c, input logic [31:0] imm);
    exp_t e;
    logic [31:0] t;
    logic [6:0] op;
    logic [1:0] sz;
    bit bad;
    op = i[6:0];
    sz = i[13:12];
    bad = 0;
    e.lat = 5; e.trp = 0; e.npc = p + 4; e.regw = int'(i[11:7] != 0);
    e.wb = 0; e.ramw = 0; e.da = 0;
    if (op == BR) begin
      t = c ? p + imm : p + 4;
      e.lat = 4; e.regw = 0; e.wb = 3; e.npc = t; bad = t[1:0] != 0;
    end else if (op == JL || op == JR) begin
      t = op == JL ? p + imm : a & ~32'd1;
      e.wb = 2; e.npc = t; bad = t[1:0] != 0;
    end else if (op == LD || op == ST) begin
      bad = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
      e.da = a[13:0];
      if (op == LD) begin e.lat = 6; e.wb = 1; end
      else begin e.regw = 0; e.wb = 3; e.ramw = 1; end
    end else if (op == MSC) begin
      e.lat = 4; e.regw = 0; e.wb = 3;
    end else if (!(op inside {OPR, OPI, AUI, LU})) begin
      e.lat = 4; e.trp = 1;
    end
    if (bad) begin e.lat = 5; e.trp = 1; end
    if (e.trp) begin e.npc = p; e.regw = 0; e.ramw = 0; e.wb = 3; e.da = 0; end
    return e;
  endfunction

  // step one instruction from a FETCH-cycle negedge until retire/trap (bounded), then one more cycle
  task automatic run_inst(input logic [31:0] instr, input logic [31:0] a, input logic c);
    o_lat = 0; o_trap = 0; o_regw = 0; o_ramw = 0; o_wb = 2'b11; o_da = 0;
    o_fetch_ok = 0; o_excl_ok = 1; o_ir = 32'hx;
    alu_out = a; cmp_out = c;
    for (int k = 1; k <= 12 && o_lat == 0; k++) begin
      if (k == 1) o_fetch_ok = state == 3'd0 && i_addr == pc[13:0];
      if (k == 3) o_ir = ir;
      if (state == 3'd4) o_da = d_addr;
      if (state == 3'd5) o_wb = wb_sel;
      o_regw += int'(reg_w_en);
      o_ramw += int'(ram_w_en);
      if (ram_w_en && reg_w_en) o_excl_ok = 0;
      if (retire || trap) begin o_lat = k; o_trap = trap; end
      inst = k == 2 ? instr : $urandom;
      @(negedge clk);
    end
    o_pc = pc;
    o_trap_end = trap;
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk);
    reset = 0;
    mpc = RESET_PC;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc, RESET_PC); end
    if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b want 0", trap); end
    if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir got %h want 0", ir); end
  endtask

  task automatic test_alu();
    run_inst(32'h00500093, 32'd5, 1'b0);
    checks += 6;
    if (o_lat !== 5) begin errors++; $display("FAIL addi_lat got %0d want 5", o_lat); end
    if (o_pc !== 32'h4) begin errors++; $display("FAIL addi_pc got %h want 4", o_pc); end
    if (o_regw !== 1) begin errors++; $display("FAIL addi_regw got %0d want 1", o_regw); end
    if (o_wb !== 2'b00) begin errors++; $display("FAIL addi_wbsel got %b want 00", o_wb); end
    if (o_ir !== 32'h00500093) begin errors++; $display("FAIL addi_ir got %h want 00500093", o_ir); end
    if (!o_fetch_ok) begin errors++; $display("FAIL addi_fetch got 0 want 1"); end
  endtask

  task automatic test_branch();
    for (int n = 0; n < 3; n++) run_inst(32'h00500093, 32'd5, 1'b0);
    run_inst(enc_b(3'b000, 32'd8), 32'h0, 1'b1);
    checks += 3;
    if (o_lat !== 4) begin errors++; $display("FAIL beq_taken_lat got %0d want 4", o_lat); end
    if (o_pc !== 32'h18) begin errors++; $display("FAIL beq_taken_pc got %h want 18", o_pc); end
    if (o_regw !== 0) begin errors++; $display("FAIL beq_taken_regw got %0d want 0", o_regw); end
    run_inst(enc_b(3'b000, 32'd8), 32'h0, 1'b0);
    checks += 2;
    if (o_lat !== 4) begin errors++; $display("FAIL beq_nt_lat got %0d want 4", o_lat); end
    if (o_pc !== 32'h1c) begin errors++; $display("FAIL beq_nt_pc got %h want 1c", o_pc); end
  endtask

  task automatic test_load();
    run_inst(32'h00012183, 32'h100, 1'b0);
    checks += 5;
    if (o_lat !== 6) begin errors++; $display("FAIL lw_lat got %0d want 6", o_lat); end
    if (o_da !== 14'h100) begin errors++; $display("FAIL lw_daddr got %h want 100", o_da); end
    if (o_wb !== 2'b01) begin errors++; $display("FAIL lw_wbsel got %b want 01", o_wb); end
    if (o_regw !== 1) begin errors++; $display("FAIL lw_regw got %0d want 1", o_regw); end
    if (o_pc !== 32'h20) begin errors++; $display("FAIL lw_pc got %h want 20", o_pc); end
  endtask

  task automatic test_store();
    run_inst(32'h00112023, 32'h104, 1'b0);
    checks += 4;
    if (o_lat !== 5) begin errors++; $display("FAIL sw_lat got %0d want 5", o_lat); end
    if (o_ramw !== 1) begin errors++; $display("FAIL sw_ramw got %0d want 1", o_ramw); end
    if (o_da !== 14'h104) begin errors++; $display("FAIL sw_daddr got %h want 104", o_da); end
    if (o_regw !== 0) begin errors++; $display("FAIL sw_regw got %0d want 0", o_regw); end
    run_inst(32'h00112023, 32'h102, 1'b0);
    checks += 4;
    if (o_trap !== 1'b1 || o_lat !== 5) begin errors++; $display("FAIL sw_mis_trap got %b@%0d want 1@5", o_trap, o_lat); end
    if (o_ramw !== 0) begin errors++; $display("FAIL sw_mis_ramw got %0d want 0", o_ramw); end
    if (o_pc !== 32'h24) begin errors++; $display("FAIL sw_mis_pc got %h want 24", o_pc); end
    if (o_trap_end !== 1'b1) begin errors++; $display("FAIL sw_mis_sticky got %b want 1", o_trap_end); end
    do_reset();
  endtask

  task automatic test_x0();
    run_inst(32'h00100013, 32'd1, 1'b0);
    checks += 3;
    if (o_lat !== 5) begin errors++; $display("FAIL x0_lat got %0d want 5", o_lat); end
    if (o_regw !== 0) begin errors++; $display("FAIL x0_regw got %0d want 0", o_regw); end
    if (o_wb !== 2'b00) begin errors++; $display("FAIL x0_wb got %b want 00", o_wb); end
  endtask

  task automatic test_ecall();
    run_inst(32'h00000073, 32'h0, 1'b0);
    checks += 3;
    if (o_trap !== 1'b1 || o_lat !== 4) begin errors++; $display("FAIL ecall_trap got %b@%0d want 1@4", o_trap, o_lat); end
    if (o_pc !== 32'h4) begin errors++; $display("FAIL ecall_pc got %h want 4", o_pc); end
    if (state !== 3'd7) begin errors++; $display("FAIL ecall_state got %0d want 7", state); end
    do_reset();
    checks += 3;
    if (state !== 3'd0) begin errors++; $display("FAIL ecall_rst_state got %0d want 0", state); end
    if (pc !== RESET_PC) begin errors++; $display("FAIL ecall_rst_pc got %h want %h", pc, RESET_PC); end
    if (trap !== 1'b0) begin errors++; $display("FAIL ecall_rst_trap got %b want 0", trap); end
  endtask

  task automatic test_jump();
    run_inst(enc_j(5'd1, 32'h20), 32'h0, 1'b0);
    checks += 4;
    if (o_lat !== 5) begin errors++; $display("FAIL jal_lat got %0d want 5", o_lat); end
    if (o_pc !== 32'h20) begin errors++; $display("FAIL jal_pc got %h want 20", o_pc); end
    if (o_wb !== 2'b10) begin errors++; $display("FAIL jal_wb got %b want 10", o_wb); end
    if (o_regw !== 1) begin errors++; $display("FAIL jal_regw got %0d want 1", o_regw); end
    run_inst(enc_i(JR, 5'd1, 3'b000, 12'h0), 32'h7, 1'b0);
    checks += 3;
    if (o_trap !== 1'b1 || o_lat !== 5) begin errors++; $display("FAIL jalr_mis_trap got %b@%0d want 1@5", o_trap, o_lat); end
    if (o_pc !== 32'h20) begin errors++; $display("FAIL jalr_mis_pc got %h want 20", o_pc); end
    if (o_regw !== 0) begin errors++; $display("FAIL jalr_mis_regw got %0d want 0", o_regw); end
    do_reset();
  endtask

  task automatic test_reset_abort();
    for (int k = 1; k <= 4; k++) begin
      inst = k == 2 ? 32'h00500093 : 32'h0;
      @(negedge clk);
    end
    checks += 1;
    if (state !== 3'd5 || reg_w_en !== 1'b1) begin errors++; $display("FAIL abort_wb got st%0d/%b want st5/1", state, reg_w_en); end
    reset = 1;
    #1;
    checks += 2;
    if (reg_w_en !== 1'b0) begin errors++; $display("FAIL abort_regw got %b want 0", reg_w_en); end
    if (retire !== 1'b0) begin errors++; $display("FAIL abort_retire got %b want 0", retire); end
    @(negedge clk);
    reset = 0;
    mpc = RESET_PC;
    checks += 2;
    if (state !== 3'd0) begin errors++; $display("FAIL abort_state got %0d want 0", state); end
    if (pc !== RESET_PC) begin errors++; $display("FAIL abort_pc got %h want %h", pc, RESET_PC); end
  endtask

`ifdef CORE_SEQ_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int n = 0; n < 3; n++) run_inst(32'h00500093, 32'd5, 1'b0);
    checks += 2;
    if (instret_cnt !== 32'd3) begin errors++; $display("FAIL perf_instret got %0d want 3", instret_cnt); end
    if (cycle_cnt !== 32'd15) begin errors++; $display("FAIL perf_cycle got %0d want 15", cycle_cnt); end
  endtask
`endif

  task automatic test_random();
    exp_t e;
    logic [31:0] ins, a, imm;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [4:0] rd;
    logic [2:0] f3;
    logic c;
    logic [6:0] bad_ops [4];
    bad_ops = '{7'b1110011, 7'b0000000, 7'b1111111, 7'b1011011};
    do_reset();
    for (int n = 0; n < 200; n++) begin
      a = $urandom; c = 1'($urandom); imm = 0; rd = 5'($urandom);
      case ($urandom_range(0, 10))
        0: ins = {7'b0, 5'($urandom), 5'($urandom), 3'($urandom), rd, OPR};
        1: ins = enc_i(OPI, rd, 3'($urandom), 12'($urandom));
        2: ins = {20'($urandom), rd, LU};
        3: ins = {20'($urandom), rd, AUI};
        4: begin
          f3 = 3'($urandom_range(0, 2)) | {$urandom_range(0, 1) == 1 && f3 != 3'd2, 2'b00};
          ins = enc_i(LD, rd, f3, 12'($urandom));
          if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        end
        5: begin
          ins = enc_s(3'($urandom_range(0, 2)), 12'($urandom));
          if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        end
        6: begin
          b13 = 13'($urandom); b13[0] = 1'b0;
          if ($urandom_range(0, 3) != 0) b13[1] = 1'b0;
          imm = {{19{b13[12]}}, b13};
          ins = enc_b(3'($urandom), imm);
        end
        7: begin
          j21 = 21'($urandom); j21[0] = 1'b0;
          if ($urandom_range(0, 3) != 0) j21[1] = 1'b0;
          imm = {{11{j21[20]}}, j21};
          ins = enc_j(rd, imm);
        end
        8: begin
          ins = enc_i(JR, rd, 3'b000, 12'($urandom));
          if ($urandom_range(0, 3) != 0) a[1] = 1'b0;
        end
        9: ins = enc_i(MSC, rd, 3'b000, 12'($urandom));
        default: ins = {25'($urandom), bad_ops[$urandom_range(0, 3)]};
      endcase
      e = model(ins, mpc, a, c, imm);
      run_inst(ins, a, c);
      checks += 9;
      if (o_lat !== e.lat) begin errors++; $display("FAIL rnd_lat[%0d] ins %h got %0d want %0d", n, ins, o_lat, e.lat); end
      if (o_trap !== e.trp) begin errors++; $display("FAIL rnd_trap[%0d] ins %h got %b want %b", n, ins, o_trap, e.trp); end
      if (o_pc !== e.npc) begin errors++; $display("FAIL rnd_pc[%0d] ins %h got %h want %h", n, ins, o_pc, e.npc); end
      if (o_regw !== e.regw) begin errors++; $display("FAIL rnd_regw[%0d] ins %h got %0d want %0d", n, ins, o_regw, e.regw); end
      if (o_ramw !== e.ramw) begin errors++; $display("FAIL rnd_ramw[%0d] ins %h got %0d want %0d", n, ins, o_ramw, e.ramw); end
      if (o_wb !== e.wb) begin errors++; $display("FAIL rnd_wb[%0d] ins %h got %b want %b", n, ins, o_wb, e.wb); end
      if (o_da !== e.da) begin errors++; $display("FAIL rnd_daddr[%0d] ins %h got %h want %h", n, ins, o_da, e.da); end
      if (o_ir !== ins) begin errors++; $display("FAIL rnd_ir[%0d] got %h want %h", n, o_ir, ins); end
      if (!o_excl_ok || !o_fetch_ok) begin errors++; $display("FAIL rnd_excl_fetch[%0d] got %b%b want 11", n, o_excl_ok, o_fetch_ok); end
      mpc = e.npc;
      if (e.trp || o_trap) do_reset();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_store();
    test_x0();
    test_ecall();
    test_jump();
    test_reset_abort();
`ifdef CORE_SEQ_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
